uart_rx: RTL and testbench

Serial receiver paired with the existing `uart_tx` path. It consumes the 8x oversampling tick from the RX `baud_generator` and the asynchronous `rx_serial` pin. It recovers 8N1 frames and presents each byte on a valid/ready output with framing-error and overrun flags. It sits between the top-level input pin and whatever consumes received bytes, such as a loopback to `uart_tx` or the output pins.

---
 rtl/uart_pkg.sv | 12 +
 rtl/sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 115 +++++++++++
 tb/tb_uart_rx.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and receiver state encoding.
package uart_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 8;
    localparam int UART_CNT_W      = $clog2(UART_OVERSAMPLE);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous pin inputs with a chosen reset value.
module sync_2ff #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] meta_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            q_o    <= RST_VAL;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with a one-entry valid/ready output and error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s, hit, good, bad;
    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_d;
    logic                 armed_q, armed_d, valid_d, fe_d, ov_d;

    sync_2ff #(.WIDTH(1), .RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_serial),
        .q_o (rx_s)
    );

    // Start sampling lands mid-bit; every later sample is one full bit apart.
    assign hit     = baud_tick && cnt_q == (state_q == START ? HALF : FULL);
    assign rx_busy = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        armed_d = armed_q | (baud_tick & rx_s);
        good    = 1'b0;
        bad     = 1'b0;
        if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    if (armed_q && !rx_s) begin
                        state_d = START;
                        cnt_d   = '0;
                    end
                end
                START: begin
                    cnt_d = hit ? '0 : cnt_q + 1'b1;
                    if (hit) begin
                        state_d = rx_s ? IDLE : DATA;
                        idx_d   = '0;
                    end
                end
                DATA: begin
                    cnt_d = hit ? '0 : cnt_q + 1'b1;
                    if (hit) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        state_d = idx_q == LAST ? STOP : DATA;
                    end
                end
                default: begin
                    cnt_d = hit ? '0 : cnt_q + 1'b1;
                    if (hit) begin
                        good    = rx_s;
                        bad     = !rx_s;
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    // A held byte that is not being taken wins; the new one is dropped.
    assign data_d  = good && (!rx_valid || rx_ready) ? shift_q : rx_data;
    assign valid_d = good | (rx_valid & ~rx_ready);
    assign fe_d    = bad;
    assign ov_d    = good & rx_valid & ~rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            armed_q   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
            rx_data   <= data_d;
            rx_valid  <= valid_d;
            frame_err <= fe_d;
            overrun   <= ov_d;
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with one baud tick every four clocks.
module tb_uart_rx;
    logic       clk = 1'b0, rst = 1'b1, baud_tick = 1'b0, rx_serial = 1'b1, rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, rx_busy;
    int         checks = 0, errors = 0, fe_cnt = 0, ov_cnt = 0, vcyc = 0;
    logic [7:0] acc_q[$];

    always #5 clk = ~clk;

    uart_rx dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .rx_serial (rx_serial),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .rx_busy   (rx_busy)
    );

    // Observe just after the driving edge: what is seen here decides the next rising edge.
    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (rx_valid && rx_ready) acc_q.push_back(rx_data);
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (rx_valid) vcyc++;
        end
    end

    task automatic tick_r(input logic r);
        repeat (3) @(negedge clk);
        baud_tick = 1'b1;
        if (r) rx_ready = 1'b1;
        @(negedge clk);
        baud_tick = 1'b0;
        if (r) rx_ready = 1'b0;
    endtask

    task automatic tick();
        tick_r(1'b0);
    endtask

    task automatic idle(input int n);
        rx_serial = 1'b1;
        repeat (n) tick();
    endtask

    task automatic bit_t(input logic v);
        rx_serial = v;
        repeat (8) tick();
    endtask

    task automatic send(input logic [7:0] b, input logic sv, input logic pulse);
        bit_t(1'b0);
        for (int i = 0; i < 8; i++) bit_t(b[i]);
        rx_serial = sv;
        for (int t = 1; t <= 8; t++) tick_r(pulse && t == 5);
        rx_serial = 1'b1;
    endtask

    task automatic clear();
        acc_q.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        vcyc   = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if ({rx_data, rx_valid, frame_err, overrun, rx_busy} !== 12'h0) begin errors++; $display("FAIL reset_outputs: got %h want 000", {rx_data, rx_valid, frame_err, overrun, rx_busy}); end
        rst = 1'b0;
        idle(4);
        checks++; if (rx_busy !== 1'b0 || rx_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: busy %b valid %b want 0 0", rx_busy, rx_valid); end
    endtask

    task automatic test_basic();
        rx_ready = 1'b1;
        clear();
        send(8'hA5, 1'b1, 1'b0);
        idle(4);
        checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_byte: got %0d bytes first %h want 1 a5", acc_q.size(), acc_q[0]); end
        checks++; if (vcyc !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d want 1", vcyc); end
        checks++; if (fe_cnt !== 0 || ov_cnt !== 0) begin errors++; $display("FAIL basic_flags: fe %0d ov %0d want 0 0", fe_cnt, ov_cnt); end
    endtask

    task automatic test_false_start();
        rx_ready = 1'b1;
        clear();
        rx_serial = 1'b0;
        tick();
        tick();
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL false_start_busy: got %b want 1", rx_busy); end
        idle(4);
        checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL false_start_idle: got %b want 0", rx_busy); end
        checks++; if (vcyc !== 0 || fe_cnt !== 0 || ov_cnt !== 0) begin errors++; $display("FAIL false_start_flags: valid %0d fe %0d ov %0d want 0 0 0", vcyc, fe_cnt, ov_cnt); end
    endtask

    task automatic test_frame_err();
        rx_ready = 1'b1;
        clear();
        send(8'h3C, 1'b0, 1'b0);
        idle(16);
        checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL frame_err_pulses: got %0d want 1", fe_cnt); end
        checks++; if (vcyc !== 0) begin errors++; $display("FAIL frame_err_valid: got %0d want 0", vcyc); end
        send(8'h3C, 1'b1, 1'b0);
        idle(4);
        checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C || fe_cnt !== 1) begin errors++; $display("FAIL frame_err_recover: got %0d bytes first %h fe %0d want 1 3c 1", acc_q.size(), acc_q[0], fe_cnt); end
    endtask

    task automatic test_overrun();
        rx_ready = 1'b0;
        clear();
        send(8'h11, 1'b1, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        idle(2);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin errors++; $display("FAIL overrun_hold: valid %b data %h want 1 11", rx_valid, rx_data); end
        checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL overrun_pulses: got %0d want 1", ov_cnt); end
        @(negedge clk);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", rx_valid); end
        checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) begin errors++; $display("FAIL overrun_accept: got %0d bytes first %h want 1 11", acc_q.size(), acc_q[0]); end
    endtask

    task automatic test_reset_mid();
        rx_ready = 1'b1;
        clear();
        bit_t(1'b0);
        bit_t(1'b1);
        bit_t(1'b0);
        bit_t(1'b1);
        rx_serial = 1'b0;
        repeat (4) tick();
        checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy: got %b want 1", rx_busy); end
        rst = 1'b1;
        repeat (3) tick();
        checks++; if ({rx_data, rx_valid, frame_err, overrun, rx_busy} !== 12'h0) begin errors++; $display("FAIL reset_mid_outputs: got %h want 000", {rx_data, rx_valid, frame_err, overrun, rx_busy}); end
        rst = 1'b0;
        repeat (10) tick();
        checks++; if (rx_busy !== 1'b0 || vcyc !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL reset_mid_unarmed: busy %b valid %0d fe %0d want 0 0 0", rx_busy, vcyc, fe_cnt); end
        idle(4);
        send(8'h55, 1'b1, 1'b0);
        idle(4);
        checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h55 || fe_cnt !== 0 || ov_cnt !== 0) begin errors++; $display("FAIL reset_mid_recover: got %0d bytes first %h fe %0d ov %0d want 1 55 0 0", acc_q.size(), acc_q[0], fe_cnt, ov_cnt); end
    endtask

    task automatic test_back_to_back();
        rx_ready = 1'b1;
        clear();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        idle(4);
        checks++; if (acc_q.size() !== 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_order: got %0d bytes %h %h want 2 00 ff", acc_q.size(), acc_q[0], acc_q[1]); end
        checks++; if (ov_cnt !== 0 || fe_cnt !== 0) begin errors++; $display("FAIL b2b_flags: ov %0d fe %0d want 0 0", ov_cnt, fe_cnt); end
        rx_ready = 1'b0;
        clear();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b1);
        idle(2);
        checks++; if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_same_cycle_overrun: got %0d want 0", ov_cnt); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_same_cycle_load: valid %b data %h want 1 ff", rx_valid, rx_data); end
        rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++; if (acc_q.size() !== 2 || acc_q[0] !== 8'h00 || acc_q[1] !== 8'hFF) begin errors++; $display("FAIL b2b_same_cycle_order: got %0d bytes %h %h want 2 00 ff", acc_q.size(), acc_q[0], acc_q[1]); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
